// File: rtl/pmem_scheduler.sv
// Arbitrates I-cache and D-cache line requests onto a single memory adapter.
// Define PMEM_SCHED_RR_EN for round-robin arbitration; otherwise D has fixed priority.
module pmem_scheduler #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_iread,
    input  logic              pmem_iwrite,
    input  logic [ADDR_W-1:0] pmem_iaddress,
    input  logic [LINE_W-1:0] pmem_iwdata,
    output logic [LINE_W-1:0] pmem_irdata,
    output logic              pmem_iresp,
    input  logic              pmem_dread,
    input  logic              pmem_dwrite,
    input  logic [ADDR_W-1:0] pmem_daddress,
    input  logic [LINE_W-1:0] pmem_dwdata,
    output logic [LINE_W-1:0] pmem_drdata,
    output logic              pmem_dresp,
    output logic              cache_read,
    output logic              cache_write,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [LINE_W-1:0] cache_wdata,
    input  logic [LINE_W-1:0] cache_rdata,
    input  logic              cache_resp,
    output logic              d_miss
);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

    state_t            state;
    logic              i_req;
    logic              d_req;
    logic              pick_d;
    logic [15:0]       grant_cnt_i;
    logic [15:0]       grant_cnt_d;
    logic [LINE_W-1:0] irdata_hold;
    logic [LINE_W-1:0] drdata_hold;

    assign i_req = pmem_iread | pmem_iwrite;
    assign d_req = pmem_dread | pmem_dwrite;

`ifdef PMEM_SCHED_RR_EN
    logic last_d;

    // On a tie the port that did not win the previous grant goes first.
    assign pick_d = d_req & (~i_req | ~last_d);
`else
    assign pick_d = d_req;
`endif

    // The cache_* outputs are the latched request itself: loaded on grant, cleared on response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cache_read  <= 1'b0;
            cache_write <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            grant_cnt_i <= '0;
            grant_cnt_d <= '0;
`ifdef PMEM_SCHED_RR_EN
            last_d      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        if (pick_d) begin
                            state       <= GRANT_D;
                            cache_write <= pmem_dwrite;
                            cache_read  <= pmem_dread & ~pmem_dwrite;
                            cache_addr  <= pmem_daddress;
                            cache_wdata <= pmem_dwdata;
                            if (grant_cnt_d != 16'hFFFF) grant_cnt_d <= grant_cnt_d + 16'd1;
                        end else begin
                            state       <= GRANT_I;
                            cache_write <= pmem_iwrite;
                            cache_read  <= pmem_iread & ~pmem_iwrite;
                            cache_addr  <= pmem_iaddress;
                            cache_wdata <= pmem_iwdata;
                            if (grant_cnt_i != 16'hFFFF) grant_cnt_i <= grant_cnt_i + 16'd1;
                        end
`ifdef PMEM_SCHED_RR_EN
                        last_d <= pick_d;
`endif
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (cache_resp) begin
                        state       <= DONE;
                        cache_read  <= 1'b0;
                        cache_write <= 1'b0;
                        cache_addr  <= '0;
                        cache_wdata <= '0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read data is forwarded in the response cycle and held afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irdata_hold <= '0;
            drdata_hold <= '0;
        end else begin
            if (pmem_iresp) irdata_hold <= cache_rdata;
            if (pmem_dresp) drdata_hold <= cache_rdata;
        end
    end

    assign pmem_iresp  = (state == GRANT_I) & cache_resp;
    assign pmem_dresp  = (state == GRANT_D) & cache_resp;
    assign pmem_irdata = pmem_iresp ? cache_rdata : irdata_hold;
    assign pmem_drdata = pmem_dresp ? cache_rdata : drdata_hold;
    assign d_miss      = ~rst & (((state == IDLE) & d_req) | (state == GRANT_D));

endmodule

// File: tb/tb_pmem_scheduler.sv
// Directed and randomized checks of pmem_scheduler against a transaction-level model.
module tb_pmem_scheduler;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
`ifdef PMEM_SCHED_RR_EN
    localparam bit RR_BUILD = 1'b1;
`else
    localparam bit RR_BUILD = 1'b0;
`endif

    typedef logic [LINE_W-1:0] w_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              pmem_iread, pmem_iwrite, pmem_dread, pmem_dwrite;
    logic [ADDR_W-1:0] pmem_iaddress, pmem_daddress;
    logic [LINE_W-1:0] pmem_iwdata, pmem_dwdata, pmem_irdata, pmem_drdata;
    logic              pmem_iresp, pmem_dresp;
    logic              cache_read, cache_write, cache_resp, d_miss;
    logic [ADDR_W-1:0] cache_addr;
    logic [LINE_W-1:0] cache_wdata, cache_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt_i = 0;
    int exp_cnt_d = 0;
    bit model_last_d = 1'b0;

    pmem_scheduler #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .pmem_iread(pmem_iread), .pmem_iwrite(pmem_iwrite), .pmem_iaddress(pmem_iaddress),
        .pmem_iwdata(pmem_iwdata), .pmem_irdata(pmem_irdata), .pmem_iresp(pmem_iresp),
        .pmem_dread(pmem_dread), .pmem_dwrite(pmem_dwrite), .pmem_daddress(pmem_daddress),
        .pmem_dwdata(pmem_dwdata), .pmem_drdata(pmem_drdata), .pmem_dresp(pmem_dresp),
        .cache_read(cache_read), .cache_write(cache_write), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_resp(cache_resp),
        .d_miss(d_miss)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic w_t rnd_line();
        w_t r;
        for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Spec-level arbitration rule: a lone requester wins; ties go to D (fixed) or the non-last winner (RR).
    function automatic bit model_pick_d(input bit ir, input bit dr);
        if (!ir) return 1'b1;
        if (!dr) return 1'b0;
        return RR_BUILD ? !model_last_d : 1'b1;
    endfunction

    task automatic set_i(input bit r, input bit w, input logic [ADDR_W-1:0] a, input w_t wd);
        pmem_iread = r; pmem_iwrite = w; pmem_iaddress = a; pmem_iwdata = wd;
    endtask

    task automatic set_d(input bit r, input bit w, input logic [ADDR_W-1:0] a, input w_t wd);
        pmem_dread = r; pmem_dwrite = w; pmem_daddress = a; pmem_dwdata = wd;
    endtask

    // Acts as the adapter for one transaction: waits for the grant, checks it, responds after lat cycles.
    task automatic run_txn(input string tag, input bit exp_d, input int lat, input w_t rdata,
                           input bit lat1, input bit mut);
        bit ew, er, granted;
        logic [ADDR_W-1:0] ea;
        w_t ewd;
        int w;
        ew  = exp_d ? pmem_dwrite : pmem_iwrite;
        er  = (exp_d ? pmem_dread : pmem_iread) & ~ew;
        ea  = exp_d ? pmem_daddress : pmem_iaddress;
        ewd = exp_d ? pmem_dwdata : pmem_iwdata;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(cache_read | cache_write) && w < 8);
        granted = cache_read | cache_write;
        chk({tag, ":grant"}, w_t'(granted), w_t'(1'b1));
        if (!granted) return;
        if (lat1) chk({tag, ":latency"}, w_t'(w), w_t'(1));
        chk({tag, ":addr"}, w_t'(cache_addr), w_t'(ea));
        chk({tag, ":read"}, w_t'(cache_read), w_t'(er));
        chk({tag, ":write"}, w_t'(cache_write), w_t'(ew));
        chk({tag, ":wdata"}, cache_wdata, ewd);
        chk({tag, ":d_miss"}, w_t'(d_miss), w_t'(exp_d));
        if (exp_d) exp_cnt_d++; else exp_cnt_i++;
        model_last_d = exp_d;
        chk({tag, ":cnt_i"}, w_t'(dut.grant_cnt_i), w_t'(exp_cnt_i));
        chk({tag, ":cnt_d"}, w_t'(dut.grant_cnt_d), w_t'(exp_cnt_d));
        for (int k = 0; k < lat; k++) begin
            if (mut && k == 0) begin
                pmem_iaddress = 32'h0000_3000;
                pmem_iwdata   = rnd_line();
            end
            @(negedge clk);
            chk({tag, ":addr_stable"}, w_t'(cache_addr), w_t'(ea));
            chk({tag, ":no_early_resp"}, w_t'(pmem_iresp | pmem_dresp), w_t'(0));
        end
        cache_rdata = rdata;
        cache_resp  = 1'b1;
        #1;
        chk({tag, ":resp"}, w_t'(exp_d ? pmem_dresp : pmem_iresp), w_t'(1));
        chk({tag, ":other_resp"}, w_t'(exp_d ? pmem_iresp : pmem_dresp), w_t'(0));
        chk({tag, ":rdata"}, exp_d ? pmem_drdata : pmem_irdata, rdata);
        @(negedge clk);
        cache_resp  = 1'b0;
        cache_rdata = rnd_line();
        #1;
        chk({tag, ":resp_pulse"}, w_t'(pmem_iresp | pmem_dresp), w_t'(0));
        chk({tag, ":done_idle_out"}, w_t'(cache_read | cache_write), w_t'(0));
        chk({tag, ":rdata_hold"}, exp_d ? pmem_drdata : pmem_irdata, rdata);
        chk({tag, ":done_d_miss"}, w_t'(d_miss), w_t'(0));
        if (exp_d) begin pmem_dread = 1'b0; pmem_dwrite = 1'b0; end
        else begin pmem_iread = 1'b0; pmem_iwrite = 1'b0; end
    endtask

    initial begin
        bit first;
        int mask;
        int op;
        rst = 1'b1;
        cache_resp = 1'b0;
        cache_rdata = '0;
        set_i(0, 0, '0, '0);
        set_d(0, 0, '0, '0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst:out", w_t'({cache_read, cache_write, pmem_iresp, pmem_dresp, d_miss}), w_t'(0));
        chk("rst:addr", w_t'(cache_addr), w_t'(0));
        chk("rst:cnt", w_t'({dut.grant_cnt_i, dut.grant_cnt_d}), w_t'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst:rdata", pmem_irdata | pmem_drdata, w_t'(0));

        // I read with 5-cycle adapter latency
        set_i(1, 0, 32'h0000_1000, '0);
        run_txn("iread", 1'b0, 5, {32{8'hA5}}, 1'b1, 1'b0);
        @(negedge clk);
        chk("iread:idle", w_t'({cache_read, cache_write, pmem_iresp}), w_t'(0));

        // Spurious adapter response while idle
        cache_resp = 1'b1;
        #1;
        chk("spur:resp", w_t'({pmem_iresp, pmem_dresp}), w_t'(0));
        @(negedge clk);
        cache_resp = 1'b0;
        chk("spur:idle", w_t'({cache_read, cache_write}), w_t'(0));
        chk("spur:cnt", w_t'({dut.grant_cnt_i, dut.grant_cnt_d}), w_t'({16'd1, 16'd0}));

        // D request with read and write both set
        @(negedge clk);
        set_d(1, 1, 32'h0000_2000, rnd_line());
        #1;
        chk("dual:d_miss_idle", w_t'(d_miss), w_t'(1));
        run_txn("dual", 1'b1, 2, rnd_line(), 1'b1, 1'b0);

        // Requester address changes during the grant
        @(negedge clk);
        set_i(1, 0, 32'h0000_1000, rnd_line());
        run_txn("stable", 1'b0, 3, rnd_line(), 1'b1, 1'b1);

        // Collision: I was the last winner
        @(negedge clk);
        set_i(1, 0, 32'h0000_5000, rnd_line());
        set_d(0, 1, 32'h0000_6000, rnd_line());
        run_txn("coll1", 1'b1, 1, rnd_line(), 1'b1, 1'b0);
        run_txn("coll2", 1'b0, 1, rnd_line(), 1'b0, 1'b0);

        // Collision with D re-raised right after its own grant
        @(negedge clk);
        set_i(1, 0, 32'h0000_7000, rnd_line());
        set_d(1, 0, 32'h0000_8000, rnd_line());
        run_txn("coll3", 1'b1, 0, rnd_line(), 1'b1, 1'b0);
        set_d(1, 0, 32'h0000_9000, rnd_line());
        run_txn("coll4", RR_BUILD ? 1'b0 : 1'b1, 1, rnd_line(), 1'b0, 1'b0);
        run_txn("coll5", RR_BUILD ? 1'b1 : 1'b0, 1, rnd_line(), 1'b0, 1'b0);

        // Reset asserted in the middle of a D read
        @(negedge clk);
        set_d(1, 0, 32'h0000_4000, '0);
        @(negedge clk);
        chk("mrst:granted", w_t'(cache_read), w_t'(1));
        cache_resp = 1'b1;
        rst = 1'b1;
        #1;
        chk("mrst:read", w_t'(cache_read), w_t'(0));
        chk("mrst:dresp", w_t'(pmem_dresp), w_t'(0));
        chk("mrst:addr", w_t'(cache_addr), w_t'(0));
        chk("mrst:d_miss", w_t'(d_miss), w_t'(0));
        pmem_dread = 1'b0;
        cache_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt_i = 0;
        exp_cnt_d = 0;
        model_last_d = 1'b0;
        @(negedge clk);
        chk("mrst:idle", w_t'({cache_read, cache_write, d_miss}), w_t'(0));
        chk("mrst:cnt", w_t'({dut.grant_cnt_i, dut.grant_cnt_d}), w_t'(0));
        chk("mrst:rdata", pmem_irdata | pmem_drdata, w_t'(0));

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            mask = int'($urandom_range(3, 1));
            if (mask[0]) begin
                op = int'($urandom_range(2, 0));
                set_i(op != 1, op != 0, $urandom, rnd_line());
            end
            if (mask[1]) begin
                op = int'($urandom_range(2, 0));
                set_d(op != 1, op != 0, $urandom, rnd_line());
            end
            first = model_pick_d(mask[0], mask[1]);
            run_txn("rnd_a", first, int'($urandom_range(3, 0)), rnd_line(), 1'b1, 1'b0);
            if (mask == 3)
                run_txn("rnd_b", !first, int'($urandom_range(3, 0)), rnd_line(), 1'b0, 1'b0);
        end
        @(negedge clk);
        chk("end:cnt_i", w_t'(dut.grant_cnt_i), w_t'(exp_cnt_i));
        chk("end:cnt_d", w_t'(dut.grant_cnt_d), w_t'(exp_cnt_d));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pmem_scheduler.md
PMEM_SCHEDULER -- requirements
Module: pmem_scheduler

Interface
REQ-001 SHALL have parameter LINE_W, default 256: cache line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32: physical address width in bits.
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have I-cache ports:
- pmem_iread  input  1  line read request, level, held until resp.
- pmem_iwrite  input  1  line write request, level, held until resp.
- pmem_iaddress  input  ADDR_W  line address.
- pmem_iwdata  input  LINE_W  write line.
- pmem_irdata  output  LINE_W  read line.
- pmem_iresp  output  1  completion pulse.
REQ-006 SHALL have D-cache ports pmem_dread, pmem_dwrite, pmem_daddress, pmem_dwdata, pmem_drdata, pmem_dresp, with the same directions, widths and meanings as REQ-005.
REQ-007 SHALL have adapter ports:
- cache_read  output  1  line read.
- cache_write  output  1  line write.
- cache_addr  output  ADDR_W  line address.
- cache_wdata  output  LINE_W  write line.
- cache_rdata  input  LINE_W  read line.
- cache_resp  input  1  adapter completion pulse.
REQ-008 SHALL have port d_miss  output  1  high while the D side is pending or granted.

Function
REQ-009 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, DONE.
REQ-010 In IDLE with at least one request, SHALL select a winner per REQ-021, latch its op, address and wdata, and enter GRANT_I or GRANT_D on the next edge.
REQ-011 In GRANT_x, SHALL drive cache_read/cache_write/cache_addr/cache_wdata only from latched values; all are 0 in IDLE and DONE.
REQ-012 A port asserting read and write together SHALL be treated as a write.
REQ-013 On cache_resp in GRANT_x, SHALL assert pmem_xresp for exactly that cycle, pass cache_rdata to pmem_xrdata combinationally, and enter DONE.
REQ-014 DONE SHALL last exactly one cycle, ignore all requests, then return to IDLE, so that a requester can drop its level request.
REQ-015 pmem_xrdata SHALL hold its last value when not responding; the non-granted port's resp SHALL stay 0.
REQ-016 Changes to requester inputs during GRANT_x SHALL NOT alter adapter outputs.
REQ-017 cache_resp in IDLE or DONE SHALL be ignored.
REQ-018 Minimum transaction latency SHALL be 1 cycle (grant) + adapter latency + 1 cycle (DONE).
REQ-019 d_miss SHALL be combinational: (pmem_dread|pmem_dwrite) in IDLE, or state==GRANT_D.
REQ-020 SHALL keep a 16-bit saturating grant counter per port, readable only hierarchically as grant_cnt_i and grant_cnt_d, incremented on entry to GRANT_x.

Reset
REQ-021 Arbitration policy SHALL be as defined under Configuration.
REQ-022 On rst assertion, regardless of state, SHALL immediately force IDLE, all outputs 0, latches and counters 0, and last-winner to I.
REQ-023 The first grant after rst deassertion SHALL occur no earlier than the first rising edge with rst low.

Configuration
REQ-024 Macro PMEM_SCHED_RR_EN SHALL select the arbitration policy.
REQ-025 With PMEM_SCHED_RR_EN defined: round-robin; on simultaneous requests the port not granted last wins; the last-winner register updates on every grant.
REQ-026 Without PMEM_SCHED_RR_EN: fixed priority; D wins every simultaneous request; the last-winner register is absent.

Verification
REQ-027 SHALL cover reset: hold rst mid GRANT_D with cache_read=1 -> same cycle cache_read=0, pmem_dresp=0; after release, IDLE and counters 0.
REQ-028 SHALL cover an I read: pmem_iread=1, pmem_iaddress=0x0000_1000, adapter resp after 5 cycles with rdata=0xA5 repeated -> cache_addr=0x1000 one cycle after request; pmem_iresp one cycle with pmem_irdata=0xA5 pattern; DONE then IDLE.
REQ-029 SHALL cover a collision: iread and dwrite raised in the same cycle, both held -> RR build: grants D then I (I was last-winner after reset); fixed build: grants D then I; with D re-raised immediately, fixed build grants D again, RR grants I.
REQ-030 SHALL cover a dual-op D request: pmem_dread=pmem_dwrite=1, pmem_daddress=0x2000 -> cache_write=1, cache_read=0, cache_addr=0x2000.
REQ-031 SHALL cover input stability: change pmem_iaddress from 0x1000 to 0x3000 during GRANT_I -> cache_addr stays 0x1000 until resp.
REQ-032 SHALL cover spurious responses: cache_resp pulsed in IDLE -> no pmem_xresp and no state change.
